// File: rtl/pll_reset_sequencer.sv
// PLLVR reset/lock sequencer: pulses the PLL reset, waits for a stable synchronised lock and
// then releases the system reset. Retries on lock timeout and latches FAIL after MAX_RETRIES.
module pll_reset_sequencer #(
   parameter int unsigned RESET_PULSE_CYCLES  = 16,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
   parameter int unsigned MAX_RETRIES         = 3,
   parameter int unsigned SYNC_STAGES         = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_lock_i,
   input  logic       soft_rst_i,
   output logic       pll_reset_o,
   output logic       sys_rst_n_o,
   output logic       ready_o,
   output logic       fail_o,
   output logic       lock_lost_o,
   output logic [3:0] retry_cnt_o
);

   localparam int unsigned RstW = (RESET_PULSE_CYCLES > 1) ? $clog2(RESET_PULSE_CYCLES) : 1;
   localparam int unsigned StbW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
   localparam int unsigned TmoW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
   localparam int unsigned StbPenInt = (LOCK_STABLE_CYCLES > 1) ? LOCK_STABLE_CYCLES - 2 : 0;

   localparam logic [RstW-1:0] RstLast  = RstW'(RESET_PULSE_CYCLES - 1);
   localparam logic [StbW-1:0] StbPen   = StbW'(StbPenInt);
   localparam logic [TmoW-1:0] TmoLast  = TmoW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [TmoW-1:0] TmoMax   = {TmoW{1'b1}};
   localparam logic [3:0]      MaxRetry = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {StPllRst, StWaitLock, StStable, StRun, StFail} state_e;

   state_e                 state_q, state_d;
   logic [RstW-1:0]        rst_cnt_q, rst_cnt_d;
   logic [StbW-1:0]        stb_cnt_q, stb_cnt_d;
   logic [TmoW-1:0]        tmo_cnt_q, tmo_cnt_d;
   logic [3:0]             retry_q, retry_d;
   logic                   lock_lost_q, lock_lost_d;
   logic                   pll_reset_q, sys_rst_n_q, ready_q, fail_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lock_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock_i};
      end
   end

   assign lock_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      stb_cnt_d   = stb_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      retry_d     = retry_q;
      lock_lost_d = lock_lost_q;
      if (soft_rst_i) begin
         state_d     = StPllRst;
         rst_cnt_d   = '0;
         stb_cnt_d   = '0;
         tmo_cnt_d   = '0;
         retry_d     = '0;
         lock_lost_d = 1'b0;
      end else begin
         case (state_q)
            StPllRst: begin
               if (rst_cnt_q == RstLast) begin
                  state_d   = StWaitLock;
                  tmo_cnt_d = '0;
                  stb_cnt_d = '0;
               end else begin
                  rst_cnt_d = rst_cnt_q + 1'b1;
               end
            end
            StWaitLock, StStable: begin
               // Timeout is tested first so it wins over a same-cycle stable completion.
               if (tmo_cnt_q == TmoLast) begin
                  if (retry_q == MaxRetry) begin
                     state_d = StFail;
                  end else begin
                     retry_d   = retry_q + 4'd1;
                     state_d   = StPllRst;
                     rst_cnt_d = '0;
                  end
               end else begin
                  if (tmo_cnt_q != TmoMax) begin
                     tmo_cnt_d = tmo_cnt_q + 1'b1;
                  end
                  if (state_q == StWaitLock) begin
                     if (lock_s) begin
                        stb_cnt_d = '0;
                        if (LOCK_STABLE_CYCLES == 1) begin
                           state_d = StRun;
                           retry_d = '0;
                        end else begin
                           state_d = StStable;
                        end
                     end
                  end else if (!lock_s) begin
                     state_d = StWaitLock;
                  end else if (stb_cnt_q == StbPen) begin
                     state_d = StRun;
                     retry_d = '0;
                  end else begin
                     stb_cnt_d = stb_cnt_q + 1'b1;
                  end
               end
            end
            StRun: begin
               if (!lock_s) begin
                  state_d     = StPllRst;
                  rst_cnt_d   = '0;
                  lock_lost_d = 1'b1;
               end
            end
            StFail: begin
               state_d = StFail;
            end
            default: begin
               state_d   = StPllRst;
               rst_cnt_d = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so each one is a single glitch-free flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StPllRst;
         rst_cnt_q   <= '0;
         stb_cnt_q   <= '0;
         tmo_cnt_q   <= '0;
         retry_q     <= '0;
         lock_lost_q <= 1'b0;
         pll_reset_q <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         stb_cnt_q   <= stb_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         retry_q     <= retry_d;
         lock_lost_q <= lock_lost_d;
         pll_reset_q <= (state_d == StPllRst) || (state_d == StFail);
         sys_rst_n_q <= (state_d == StRun);
         ready_q     <= (state_d == StRun);
         fail_q      <= (state_d == StFail);
      end
   end

   assign pll_reset_o = pll_reset_q;
   assign sys_rst_n_o = sys_rst_n_q;
   assign ready_o     = ready_q;
   assign fail_o      = fail_q;
   assign lock_lost_o = lock_lost_q;
   assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: a phase/run-length model checked every cycle, plus directed
// scenarios with literal expectations at hand-computed cycle numbers.
module tb_pll_reset_sequencer;

   localparam int P    = 4;
   localparam int S    = 8;
   localparam int T    = 32;
   localparam int R    = 2;
   localparam int SYNC = 2;

   localparam int PH_RST  = 0;
   localparam int PH_ACQ  = 1;
   localparam int PH_RUN  = 2;
   localparam int PH_FAIL = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       pll_lock_i = 1'b0;
   logic       soft_rst_i = 1'b0;
   logic       pll_reset_o, sys_rst_n_o, ready_o, fail_o, lock_lost_o;
   logic [3:0] retry_cnt_o;

   int total = 0;
   int bad   = 0;
   int falls = 0;
   int cyc   = 0;
   bit chk_on = 1'b0;

   // Model state: phase, cycles in phase/attempt, consecutive lock_s-high cycles in attempt.
   int            m_phase = PH_RST;
   int            m_age   = 0;
   int            m_run   = 0;
   int            m_retry = 0;
   int            m_lost  = 0;
   logic [SYNC-1:0] hist = '0;
   logic          ls;

   pll_reset_sequencer #(
      .RESET_PULSE_CYCLES (P),
      .LOCK_STABLE_CYCLES (S),
      .LOCK_TIMEOUT_CYCLES(T),
      .MAX_RETRIES        (R),
      .SYNC_STAGES        (SYNC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pll_lock_i (pll_lock_i),
      .soft_rst_i (soft_rst_i),
      .pll_reset_o(pll_reset_o),
      .sys_rst_n_o(sys_rst_n_o),
      .ready_o    (ready_o),
      .fail_o     (fail_o),
      .lock_lost_o(lock_lost_o),
      .retry_cnt_o(retry_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, got, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_phase = PH_RST;
            m_age   = 0;
            m_run   = 0;
            m_retry = 0;
            m_lost  = 0;
            hist    = '0;
            cyc     = 0;
         end else begin
            ls   = hist[SYNC-1];
            hist = {hist[SYNC-2:0], pll_lock_i};
            cyc++;
            if (soft_rst_i) begin
               m_phase = PH_RST;
               m_age   = 0;
               m_retry = 0;
               m_lost  = 0;
            end else begin
               case (m_phase)
                  PH_RST: begin
                     m_age++;
                     if (m_age == P) begin
                        m_phase = PH_ACQ;
                        m_age   = 0;
                        m_run   = 0;
                     end
                  end
                  PH_ACQ: begin
                     if (m_age == T - 1) begin
                        if (m_retry == R) begin
                           m_phase = PH_FAIL;
                        end else begin
                           m_retry++;
                           m_phase = PH_RST;
                           m_age   = 0;
                        end
                     end else begin
                        m_age++;
                        m_run = ls ? m_run + 1 : 0;
                        if (m_run == S) begin
                           m_phase = PH_RUN;
                           m_retry = 0;
                        end
                     end
                  end
                  PH_RUN: begin
                     if (!ls) begin
                        m_phase = PH_RST;
                        m_age   = 0;
                        m_lost  = 1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   initial begin
      logic prev_pr;
      prev_pr = 1'b1;
      forever begin
         @(negedge clk);
         if (chk_on) begin
            chk("pll_reset_o", int'(pll_reset_o),
                int'((m_phase == PH_RST) || (m_phase == PH_FAIL)));
            chk("sys_rst_n_o", int'(sys_rst_n_o), int'(m_phase == PH_RUN));
            chk("ready_o", int'(ready_o), int'(m_phase == PH_RUN));
            chk("fail_o", int'(fail_o), int'(m_phase == PH_FAIL));
            chk("lock_lost_o", int'(lock_lost_o), m_lost);
            chk("retry_cnt_o", int'(retry_cnt_o), m_retry);
         end
         if (prev_pr && !pll_reset_o) falls++;
         prev_pr = pll_reset_o;
      end
   end

   task automatic do_reset();
      rst_n      = 1'b0;
      pll_lock_i = 1'b0;
      soft_rst_i = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      falls = 0;
   endtask

   task automatic to_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      #1;
      do_reset();
      chk_on = 1'b1;

      // 1: lock from cycle 10, release 10 cycles later; then 4: lock loss in RUN
      chk("t1 reset pll_reset", int'(pll_reset_o), 1);
      chk("t1 reset sys_rst_n", int'(sys_rst_n_o), 0);
      to_cyc(3);
      chk("t1 pulse cyc3", int'(pll_reset_o), 1);
      to_cyc(4);
      chk("t1 pulse end cyc4", int'(pll_reset_o), 0);
      to_cyc(10);
      pll_lock_i = 1'b1;
      to_cyc(19);
      chk("t1 sys_rst_n cyc19", int'(sys_rst_n_o), 0);
      to_cyc(20);
      chk("t1 sys_rst_n cyc20", int'(sys_rst_n_o), 1);
      chk("t1 ready cyc20", int'(ready_o), 1);
      chk("t1 retry", int'(retry_cnt_o), 0);
      to_cyc(30);
      pll_lock_i = 1'b0;
      to_cyc(32);
      chk("t4 sys_rst_n cyc32", int'(sys_rst_n_o), 1);
      to_cyc(33);
      chk("t4 sys_rst_n cyc33", int'(sys_rst_n_o), 0);
      chk("t4 pll_reset cyc33", int'(pll_reset_o), 1);
      chk("t4 lock_lost cyc33", int'(lock_lost_o), 1);
      to_cyc(34);
      pll_lock_i = 1'b1;
      to_cyc(44);
      chk("t4 relock cyc44", int'(sys_rst_n_o), 0);
      to_cyc(45);
      chk("t4 relock cyc45", int'(sys_rst_n_o), 1);
      chk("t4 lock_lost sticky", int'(lock_lost_o), 1);
      to_cyc(47);
      soft_rst_i = 1'b1;
      to_cyc(48);
      soft_rst_i = 1'b0;
      chk("t4 lock_lost cleared", int'(lock_lost_o), 0);
      chk("t4 soft pll_reset", int'(pll_reset_o), 1);
      to_cyc(60);

      // 2: never locks -> FAIL after third timeout; then 5: soft reset recovery
      do_reset();
      to_cyc(35);
      chk("t2 retry cyc35", int'(retry_cnt_o), 0);
      to_cyc(36);
      chk("t2 retry cyc36", int'(retry_cnt_o), 1);
      chk("t2 pll_reset cyc36", int'(pll_reset_o), 1);
      to_cyc(72);
      chk("t2 retry cyc72", int'(retry_cnt_o), 2);
      to_cyc(107);
      chk("t2 fail cyc107", int'(fail_o), 0);
      to_cyc(108);
      chk("t2 fail cyc108", int'(fail_o), 1);
      chk("t2 fail pll_reset", int'(pll_reset_o), 1);
      chk("t2 fail sys_rst_n", int'(sys_rst_n_o), 0);
      chk("t2 fail retry", int'(retry_cnt_o), 2);
      to_cyc(110);
      chk("t2 pulse count", falls, 3);
      pll_lock_i = 1'b1;
      soft_rst_i = 1'b1;
      to_cyc(111);
      soft_rst_i = 1'b0;
      chk("t5 fail cleared", int'(fail_o), 0);
      chk("t5 retry cleared", int'(retry_cnt_o), 0);
      to_cyc(114);
      chk("t5 pulse cyc114", int'(pll_reset_o), 1);
      to_cyc(115);
      chk("t5 pulse end cyc115", int'(pll_reset_o), 0);
      to_cyc(122);
      chk("t5 run cyc122", int'(sys_rst_n_o), 0);
      to_cyc(123);
      chk("t5 run cyc123", int'(sys_rst_n_o), 1);
      to_cyc(125);
      pll_lock_i = 1'b0;
      to_cyc(127);
      soft_rst_i = 1'b1;
      to_cyc(128);
      soft_rst_i = 1'b0;
      chk("t5 soft vs loss lock_lost", int'(lock_lost_o), 0);
      chk("t5 soft vs loss sys_rst_n", int'(sys_rst_n_o), 0);
      to_cyc(129);
      chk("t5 lock_lost stays 0", int'(lock_lost_o), 0);

      // 3: one-cycle lock glitch at stable count 5
      do_reset();
      to_cyc(10);
      pll_lock_i = 1'b1;
      to_cyc(16);
      pll_lock_i = 1'b0;
      to_cyc(17);
      pll_lock_i = 1'b1;
      to_cyc(26);
      chk("t3 no release cyc26", int'(sys_rst_n_o), 0);
      to_cyc(27);
      chk("t3 release cyc27", int'(sys_rst_n_o), 1);
      chk("t3 retry", int'(retry_cnt_o), 0);

      // 6: asynchronous reset mid-STABLE
      do_reset();
      to_cyc(10);
      pll_lock_i = 1'b1;
      to_cyc(16);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6 async pll_reset", int'(pll_reset_o), 1);
      chk("t6 async sys_rst_n", int'(sys_rst_n_o), 0);
      chk("t6 async ready", int'(ready_o), 0);
      chk("t6 async fail", int'(fail_o), 0);
      chk("t6 async lock_lost", int'(lock_lost_o), 0);
      chk("t6 async retry", int'(retry_cnt_o), 0);
      repeat (2) @(posedge clk);
      #2;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
